// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step/halt/reset controller gating a single-cycle RV32I core.
// Breakpoint support (bp_addr, bp_valid, skip_bp) is compiled in when RUN_CTRL_BREAKPOINT_EN is defined.
module core_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter logic [31:0] EBREAK_WORD = 32'h00100073
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [31:0] core_pc,
    input  logic [31:0] core_instr,
    output logic        core_en,
    output logic        core_rst,
    output logic [1:0]  state,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
);
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HALT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam logic [2:0]  OP_RUN       = 3'd1;
    localparam logic [2:0]  OP_STEP      = 3'd2;
    localparam logic [2:0]  OP_HALT      = 3'd3;
    localparam logic [2:0]  OP_RESET     = 3'd4;
    localparam logic [1:0]  CAUSE_HOST   = 2'd0;
    localparam logic [1:0]  CAUSE_STEP   = 2'd1;
    localparam logic [1:0]  CAUSE_EBREAK = 2'd2;
    localparam logic [1:0]  CAUSE_BP     = 2'd3;
    localparam logic [31:0] RST_LOAD     = 32'(RST_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]  halt_cause_q, halt_cause_d;
    logic [31:0] steps_left_q, steps_left_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic        accept_s;
    logic        ebreak_s;
    logic        bp_hit_s;
    logic        stop_now_s;
    logic        executing_s;
    logic        resume_s;
    logic        rst_cmd_s;
    logic [31:0] step_load_s;

    assign cmd_ready   = (state_q != ST_RESET);
    assign accept_s    = cmd_valid && cmd_ready;
    assign ebreak_s    = (core_instr == EBREAK_WORD);
    assign stop_now_s  = ebreak_s || bp_hit_s;
    assign executing_s = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign core_en     = executing_s && !stop_now_s;
    assign core_rst    = (state_q == ST_RESET);
    assign state       = state_q;
    assign halt_cause  = halt_cause_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign retire_cnt  = retire_cnt_q;
    assign step_load_s = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;

    // Next-state, halt cause, step budget and counters.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        halt_cause_d = halt_cause_q;
        steps_left_d = steps_left_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        resume_s     = 1'b0;
        rst_cmd_s    = 1'b0;

        if (executing_s) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
        if (core_en) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
        if (core_en && (state_q == ST_STEP)) begin
            steps_left_d = steps_left_q - 32'd1;
        end else begin
            steps_left_d = steps_left_q;
        end

        case (state_q)
            ST_RESET: begin
                if (rst_cnt_q == 32'd0) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_HOST;
                end else begin
                    rst_cnt_d = rst_cnt_q - 32'd1;
                end
            end
            ST_HALT: begin
                // After EBREAK only RESET_CORE may leave HALT.
                if (accept_s && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP)) &&
                    (halt_cause_q != CAUSE_EBREAK)) begin
                    resume_s = 1'b1;
                    if (cmd_op == OP_STEP) begin
                        state_d      = ST_STEP;
                        steps_left_d = step_load_s;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_RUN, ST_STEP: begin
                // Automatic stops outrank step completion, which outranks host commands.
                if (stop_now_s) begin
                    state_d      = ST_HALT;
                    halt_cause_d = ebreak_s ? CAUSE_EBREAK : CAUSE_BP;
                end else if ((state_q == ST_STEP) && core_en && (steps_left_q == 32'd1)) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_STEP;
                end else if (accept_s && (cmd_op == OP_HALT)) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_HOST;
                end else if (accept_s && (cmd_op == OP_RUN)) begin
                    state_d = ST_RUN;
                end else if (accept_s && (cmd_op == OP_STEP) && (state_q == ST_RUN)) begin
                    state_d      = ST_STEP;
                    steps_left_d = step_load_s;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (accept_s && (cmd_op == OP_RESET)) begin
            rst_cmd_s    = 1'b1;
            state_d      = ST_RESET;
            rst_cnt_d    = RST_LOAD;
            halt_cause_d = CAUSE_HOST;
            steps_left_d = 32'd0;
            cycle_cnt_d  = 32'd0;
            retire_cnt_d = 32'd0;
        end else begin
            rst_cmd_s = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_RESET;
            rst_cnt_q    <= RST_LOAD;
            halt_cause_q <= CAUSE_HOST;
            steps_left_q <= 32'd0;
            cycle_cnt_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            halt_cause_q <= halt_cause_d;
            steps_left_q <= steps_left_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam logic [2:0] OP_SET_BP = 3'd5;
    localparam logic [2:0] OP_CLR_BP = 3'd6;

    logic [31:0] bp_addr_q, bp_addr_d;
    logic        bp_valid_q, bp_valid_d;
    logic        skip_bp_q, skip_bp_d;

    assign bp_hit_s = bp_valid_q && (core_pc == bp_addr_q) && !skip_bp_q;

    // Breakpoint registers; skip_bp lets one instruction retire at the breakpoint PC on resume.
    always_comb begin
        bp_addr_d  = bp_addr_q;
        bp_valid_d = bp_valid_q;
        skip_bp_d  = skip_bp_q;
        if (accept_s && (cmd_op == OP_SET_BP)) begin
            bp_addr_d  = cmd_arg;
            bp_valid_d = 1'b1;
        end else if (accept_s && (cmd_op == OP_CLR_BP)) begin
            bp_valid_d = 1'b0;
        end else begin
            bp_valid_d = bp_valid_q;
        end
        if (rst_cmd_s || core_en) begin
            skip_bp_d = 1'b0;
        end else if (resume_s && (halt_cause_q == CAUSE_BP)) begin
            skip_bp_d = 1'b1;
        end else begin
            skip_bp_d = skip_bp_q;
        end
    end

    // Breakpoint state registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            bp_addr_q  <= 32'd0;
            bp_valid_q <= 1'b0;
            skip_bp_q  <= 1'b0;
        end else begin
            bp_addr_q  <= bp_addr_d;
            bp_valid_q <= bp_valid_d;
            skip_bp_q  <= skip_bp_d;
        end
    end
`else
    logic unused_bp_s;

    assign bp_hit_s    = 1'b0;
    assign unused_bp_s = ^{core_pc, resume_s, rst_cmd_s};
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: a behavioural model plus a tiny core model predict every cycle's outputs.
module tb_core_run_ctrl;
    localparam int          RST_CYCLES = 4;
    localparam logic [31:0] EBREAK     = 32'h00100073;
    localparam logic [31:0] NOP        = 32'h00000013;
`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [31:0] core_pc = 32'd0;
    logic [31:0] core_instr = 32'd0;
    logic        core_en;
    logic        core_rst;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    always #5 CLK = ~CLK;

    core_run_ctrl #(.RST_CYCLES(RST_CYCLES), .EBREAK_WORD(EBREAK)) dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .core_pc(core_pc), .core_instr(core_instr),
        .core_en(core_en), .core_rst(core_rst), .state(state), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        rst;
        logic        en;
        logic        rdy;
        logic [1:0]  cause;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: mode 0 RESET, 1 HALT, 2 RUN, 3 STEP.
    bit          m_known = 1'b0;
    int          m_state = 0;
    logic [31:0] m_rst_cnt = 32'd0;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;
    logic [31:0] m_steps = 32'd0;
    bit          m_bpv = 1'b0;
    bit          m_skip = 1'b0;
    logic [31:0] m_bpa = 32'd0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] mem [64];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Monitor: compares each cycle's DUT outputs against the queued prediction.
    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("state", {30'd0, state}, {30'd0, e.st});
            chk("core_rst", {31'd0, core_rst}, {31'd0, e.rst});
            chk("core_en", {31'd0, core_en}, {31'd0, e.en});
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.rdy});
            chk("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
            chk("cycle_cnt", cycle_cnt, e.cyc);
            chk("retire_cnt", retire_cnt, e.ret);
        end
    end

    task automatic cyc(input bit rst, input bit v, input logic [2:0] op, input logic [31:0] arg);
        exp_t        e;
        logic [31:0] instr;
        bit          eb, stop, en, acc, done;
        instr = mem[m_pc[7:2]];
        reset = rst; cmd_valid = v; cmd_op = op; cmd_arg = arg;
        core_pc = m_pc; core_instr = instr;
        eb   = (instr == EBREAK);
        stop = eb || (BP_EN && m_bpv && (m_pc == m_bpa) && !m_skip);
        en   = (m_state == 2 || m_state == 3) && !stop;
        e.st = 2'(m_state); e.rst = (m_state == 0); e.en = en; e.rdy = (m_state != 0);
        e.cause = m_cause; e.cyc = m_cyc; e.ret = m_ret;
        if (m_known) sb_q.push_back(e);
        @(posedge CLK);
        if (rst) begin
            m_known = 1'b1; m_state = 0; m_rst_cnt = RST_CYCLES - 1; m_cause = 2'd0;
            m_cyc = 0; m_ret = 0; m_steps = 0; m_bpv = 0; m_skip = 0; m_bpa = 0; m_pc = 0;
        end else begin
            acc = v && (m_state != 0);
            if (m_state == 0) m_pc = 0;
            else if (en) m_pc = m_pc + 4;
            if (m_state >= 2) m_cyc = m_cyc + 1;
            if (en) m_ret = m_ret + 1;
            if (m_state == 0) begin
                if (m_rst_cnt == 0) begin m_state = 1; m_cause = 2'd0; end
                else m_rst_cnt = m_rst_cnt - 1;
            end else if (acc && op == 3'd4) begin
                m_state = 0; m_rst_cnt = RST_CYCLES - 1; m_cause = 2'd0;
                m_cyc = 0; m_ret = 0; m_steps = 0; m_skip = 0;
            end else begin
                if (en) m_skip = 0;
                if (acc && BP_EN && op == 3'd5) begin m_bpv = 1; m_bpa = arg; end
                if (acc && BP_EN && op == 3'd6) m_bpv = 0;
                if (m_state == 1) begin
                    if (acc && (op == 3'd1 || op == 3'd2) && m_cause != 2'd2) begin
                        if (m_cause == 2'd3) m_skip = 1;
                        m_state = (op == 3'd1) ? 2 : 3;
                        if (op == 3'd2) m_steps = (arg == 0) ? 32'd1 : arg;
                    end
                end else begin
                    done = (m_state == 3) && en && (m_steps == 1);
                    if (m_state == 3 && en) m_steps = m_steps - 1;
                    if (stop) begin m_state = 1; m_cause = eb ? 2'd2 : 2'd3; end
                    else if (done) begin m_state = 1; m_cause = 2'd1; end
                    else if (acc && op == 3'd3) begin m_state = 1; m_cause = 2'd0; end
                    else if (acc && op == 3'd1) m_state = 2;
                    else if (acc && op == 3'd2 && m_state == 2) begin
                        m_state = 3; m_steps = (arg == 0) ? 32'd1 : arg;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
        cyc(1'b0, 1'b1, op, arg);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rarg;
        int          r;
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[8] = EBREAK;

        // Reset for one cycle, then RST_CYCLES cycles of core_rst and settle in HALT.
        cyc(1'b1, 1'b0, 3'd0, 32'd0);
        idle(7);

        // RUN into EBREAK at 0x20; later RUN is ignored; RESET_CORE clears counters.
        cmd(3'd1, 32'd0);
        idle(12);
        cmd(3'd1, 32'd0);
        idle(3);
        cmd(3'd2, 32'd2);
        idle(2);
        cmd(3'd4, 32'd0);
        idle(6);

        // STEP 3, then STEP 0 (one instruction).
        mem[8] = NOP; mem[60] = EBREAK;
        cmd(3'd2, 32'd3);
        idle(6);
        cmd(3'd2, 32'd0);
        idle(4);

        // Breakpoint at 0x10, then resume past it.
        cmd(3'd4, 32'd0);
        idle(6);
        cmd(3'd5, 32'h10);
        cmd(3'd1, 32'd0);
        idle(8);
        cmd(3'd1, 32'd0);
        idle(5);
        cmd(3'd3, 32'd0);
        idle(2);

        // HALT command mid-run; instruction in the accept cycle retires.
        cmd(3'd4, 32'd0);
        idle(6);
        cmd(3'd6, 32'd0);
        cmd(3'd1, 32'd0);
        idle(4);
        cmd(3'd3, 32'd0);
        idle(3);

        // Mode switches and STEP completing together with a HALT command.
        cmd(3'd1, 32'd0);
        cmd(3'd2, 32'd2);
        idle(1);
        cmd(3'd3, 32'd0);
        idle(2);
        cmd(3'd2, 32'd5);
        cmd(3'd1, 32'd0);
        idle(2);
        cmd(3'd3, 32'd0);
        idle(2);

        // cycle_cnt wrap from 0xFFFFFFFF after one RUN cycle.
        force dut.cycle_cnt_q = 32'hFFFFFFFF;
        m_cyc = 32'hFFFFFFFF;
        idle(2);
        release dut.cycle_cnt_q;
        idle(1);
        cmd(3'd1, 32'd0);
        cmd(3'd3, 32'd0);
        idle(2);

        // RESET_CORE during STEP with steps left; breakpoint survives it.
        cmd(3'd4, 32'd0);
        idle(6);
        cmd(3'd5, 32'h20);
        cmd(3'd2, 32'd10);
        idle(3);
        cmd(3'd4, 32'd0);
        idle(6);
        cmd(3'd1, 32'd0);
        idle(12);
        cmd(3'd2, 32'd3);
        idle(5);

        // Randomized traffic, including reserved opcodes and mid-run global resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                for (int k = 0; k < 64; k++) mem[k] = ($urandom_range(0, 19) == 0) ? EBREAK : NOP;
            end
            r    = $urandom_range(0, 99);
            rop  = 3'($urandom_range(0, 7));
            rarg = (rop == 3'd5) ? {24'd0, 6'($urandom_range(0, 63)), 2'b00}
                                 : 32'($urandom_range(0, 6));
            if (r < 1) cyc(1'b1, 1'b0, rop, rarg);
            else if (r < 30) cyc(1'b0, 1'b1, rop, rarg);
            else cyc(1'b0, 1'b0, rop, rarg);
        end
        idle(2);
        @(negedge CLK);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
